uart_cmd_ctrl: RTL
==================

Name: uart_cmd_ctrl

Overview:
- Command controller on the internal side of the UART.
- Consumes received bytes, decodes multi-byte command frames, and drives register-file and ALU requests.
- Pushes response bytes into the TX-side FIFO that feeds the UART transmitter.
- Sits between the UART RX/TX data interfaces and the system register file and ALU. Single clock domain: the RX clock-domain data is already synchronised, and TX crossing is handled by the FIFO.

Parameters:
- DATA_WIDTH, 8, width of UART bytes, register data and ALU operands.
- ADDR_WIDTH, 4, register-file address width; the address is taken from byte bits [ADDR_WIDTH-1:0].
- ALU_FUN_WIDTH, 4, ALU function code width; taken from byte bits [ALU_FUN_WIDTH-1:0].

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous active-low reset.
- RX_DATA  in  DATA_WIDTH  received byte.
- RX_DATA_VALID  in  1  one-cycle pulse, RX_DATA valid.
- RX_PAR_ERROR  in  1  parity error qualifier for the current byte.
- RX_STOP_ERROR  in  1  stop error qualifier for the current byte.
- TX_FIFO_DATA  out  DATA_WIDTH  response byte.
- TX_FIFO_WR  out  1  one-cycle write strobe into the TX FIFO.
- TX_FIFO_FULL  in  1  FIFO full; no write while high.
- RF_ADDR  out  ADDR_WIDTH  register address.
- RF_WR_EN  out  1  register write pulse.
- RF_WR_DATA  out  DATA_WIDTH  register write data.
- RF_RD_EN  out  1  register read pulse.
- RF_RD_DATA  in  DATA_WIDTH  register read data.
- RF_RD_VALID  in  1  read data valid.
- ALU_EN  out  1  ALU start pulse.
- ALU_FUN  out  ALU_FUN_WIDTH  ALU function.
- ALU_OUT  in  2*DATA_WIDTH  ALU result.
- ALU_OUT_VALID  in  1  result valid.
- FRAME_ERR  out  1  one-cycle pulse when a frame is aborted.

Behaviour:
- Reset: the asynchronous active-low RST forces state IDLE.
  - All outputs go to 0: strobes, RF_ADDR, RF_WR_DATA, ALU_FUN, TX_FIFO_DATA, FRAME_ERR.
  - Internal operand and result registers clear to 0.
  - Reset mid-frame discards the frame; no strobe is emitted after release until a new frame starts.
- Byte acceptance: a byte is accepted only on RX_DATA_VALID=1 while the state is IDLE or one of the collection states. A byte with RX_PAR_ERROR or RX_STOP_ERROR high is bad.
  - A bad byte in a collection state: go to IDLE and pulse FRAME_ERR.
  - A bad byte in IDLE: ignored, no FRAME_ERR.
- Command codes (first byte of a frame):
  - 0xAA register write: ADDR, DATA.
  - 0xBB register read: ADDR.
  - 0xCC ALU with operands: OPA, OPB, FUN.
  - 0xDD ALU without operands: FUN.
  - Any other byte in IDLE is ignored silently.
- State transitions:
  - IDLE -> WR_ADDR / RD_ADDR / OPA / FUN on the command byte.
  - WR_ADDR -> WR_DATA.
  - WR_DATA: on the data byte, pulse RF_WR_EN the next cycle with RF_ADDR and RF_WR_DATA held stable; -> IDLE.
  - RD_ADDR: on the address byte, pulse RF_RD_EN the next cycle; -> RD_WAIT.
  - RD_WAIT: on RF_RD_VALID, capture RF_RD_DATA; -> SEND_LO, single byte response.
  - OPA: on the byte, write it to RF address 0 (RF_WR_EN pulse); -> OPB.
  - OPB: on the byte, write it to RF address 1; -> FUN.
  - FUN: on the byte, pulse ALU_EN the next cycle with ALU_FUN; -> ALU_WAIT.
  - ALU_WAIT: on ALU_OUT_VALID, capture ALU_OUT; -> SEND_LO.
  - SEND_LO: push the low byte (or the read byte) when TX_FIFO_FULL=0.
    - For ALU responses -> SEND_HI.
    - Otherwise -> IDLE.
  - SEND_HI: push ALU_OUT[15:8] when not full; -> IDLE.
- Strobes are exactly one cycle wide and registered. TX_FIFO_DATA is valid in the cycle of TX_FIFO_WR.
- TX_FIFO_FULL high: remain in the SEND state with no strobe. The write happens the first cycle full is low. Bytes are never lost or duplicated.
- RX bytes arriving in RD_WAIT, ALU_WAIT, SEND_LO or SEND_HI are dropped; they do not start a new frame and do not pulse FRAME_ERR.
- RF_RD_VALID or ALU_OUT_VALID outside its wait state is ignored.
- Minimum latency:
  - Last frame byte to RF_WR_EN: 1 cycle.
  - FUN byte to ALU_EN: 1 cycle.
  - ALU_OUT_VALID to first TX_FIFO_WR: 1 cycle when not full.
- No timeout: the wait states hold until the valid signal arrives.

Test Plan:
- Register write: bytes 0xAA, 0x05, 0x3C -> one RF_WR_EN pulse, RF_ADDR=5, RF_WR_DATA=0x3C, one cycle after the 0x3C valid; no TX write.
- Register read: 0xBB, 0x07; RF model returns 0x9E two cycles after RF_RD_EN -> exactly one TX_FIFO_WR with data 0x9E.
- ALU with operands: 0xCC, 0x12, 0x34, 0x02 -> writes RF[0]=0x12 and RF[1]=0x34, ALU_EN with ALU_FUN=2; ALU_OUT=0x0246 -> TX writes 0x46 then 0x02.
- Backpressure: 0xDD, 0x01 with ALU_OUT=0xABCD and TX_FIFO_FULL held high 5 cycles -> no writes while full, then 0xCD, 0xAB in order, each exactly once.
- Errors: 0xAA, then 0x03 with RX_PAR_ERROR=1 -> FRAME_ERR pulse, IDLE, no RF_WR_EN. Unknown byte 0x55 in IDLE -> no action. Byte 0xAA during ALU_WAIT -> dropped.
- Reset mid-frame: assert RST after 0xCC, 0x11 -> all outputs 0; after release, frame 0xAA, 0x01, 0x22 works normally.

Source files
------------

// File: rtl/uart_cmd_ctrl.sv
// UART command controller: decodes RX command frames into register-file/ALU requests and queues response bytes to the TX FIFO.
// All strobes are registered one-cycle pulses; response pushes stall while TX_FIFO_FULL is high.
module uart_cmd_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int ALU_FUN_WIDTH = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     RX_DATA,
  input  logic                      RX_DATA_VALID,
  input  logic                      RX_PAR_ERROR,
  input  logic                      RX_STOP_ERROR,
  output logic [DATA_WIDTH-1:0]     TX_FIFO_DATA,
  output logic                      TX_FIFO_WR,
  input  logic                      TX_FIFO_FULL,
  output logic [ADDR_WIDTH-1:0]     RF_ADDR,
  output logic                      RF_WR_EN,
  output logic [DATA_WIDTH-1:0]     RF_WR_DATA,
  output logic                      RF_RD_EN,
  input  logic [DATA_WIDTH-1:0]     RF_RD_DATA,
  input  logic                      RF_RD_VALID,
  output logic                      ALU_EN,
  output logic [ALU_FUN_WIDTH-1:0]  ALU_FUN,
  input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
  input  logic                      ALU_OUT_VALID,
  output logic                      FRAME_ERR
);

  localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_NO = DATA_WIDTH'(8'hDD);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT,
    OPA, OPB, FUN, ALU_WAIT, SEND_LO, SEND_HI
  } state_t;

  state_t                     state, state_nxt;
  logic [2*DATA_WIDTH-1:0]    result, result_nxt;
  logic                       is_alu, is_alu_nxt;
  logic [ADDR_WIDTH-1:0]      rf_addr_nxt;
  logic [DATA_WIDTH-1:0]      rf_wr_data_nxt, tx_data_nxt;
  logic [ALU_FUN_WIDTH-1:0]   alu_fun_nxt;
  logic                       rf_wr_en_nxt, rf_rd_en_nxt, alu_en_nxt, tx_wr_nxt, frame_err_nxt;
  logic                       rx_bad, collecting;

  assign rx_bad     = RX_PAR_ERROR | RX_STOP_ERROR;
  assign collecting = (state inside {WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB, FUN});

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= IDLE;
      result       <= '0;
      is_alu       <= 1'b0;
      RF_ADDR      <= '0;
      RF_WR_DATA   <= '0;
      ALU_FUN      <= '0;
      TX_FIFO_DATA <= '0;
      RF_WR_EN     <= 1'b0;
      RF_RD_EN     <= 1'b0;
      ALU_EN       <= 1'b0;
      TX_FIFO_WR   <= 1'b0;
      FRAME_ERR    <= 1'b0;
    end else begin
      state        <= state_nxt;
      result       <= result_nxt;
      is_alu       <= is_alu_nxt;
      RF_ADDR      <= rf_addr_nxt;
      RF_WR_DATA   <= rf_wr_data_nxt;
      ALU_FUN      <= alu_fun_nxt;
      TX_FIFO_DATA <= tx_data_nxt;
      RF_WR_EN     <= rf_wr_en_nxt;
      RF_RD_EN     <= rf_rd_en_nxt;
      ALU_EN       <= alu_en_nxt;
      TX_FIFO_WR   <= tx_wr_nxt;
      FRAME_ERR    <= frame_err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    result_nxt     = result;
    is_alu_nxt     = is_alu;
    rf_addr_nxt    = RF_ADDR;
    rf_wr_data_nxt = RF_WR_DATA;
    alu_fun_nxt    = ALU_FUN;
    tx_data_nxt    = TX_FIFO_DATA;
    rf_wr_en_nxt   = 1'b0;
    rf_rd_en_nxt   = 1'b0;
    alu_en_nxt     = 1'b0;
    tx_wr_nxt      = 1'b0;
    frame_err_nxt  = 1'b0;

    if (collecting && RX_DATA_VALID && rx_bad) begin
      state_nxt     = IDLE;
      frame_err_nxt = 1'b1;
    end else begin
      case (state)
        IDLE: if (RX_DATA_VALID && !rx_bad) begin
          case (RX_DATA)
            CMD_WR:     state_nxt = WR_ADDR;
            CMD_RD:     state_nxt = RD_ADDR;
            CMD_ALU_OP: state_nxt = OPA;
            CMD_ALU_NO: state_nxt = FUN;
            default:    state_nxt = IDLE;
          endcase
        end
        WR_ADDR: if (RX_DATA_VALID) begin
          rf_addr_nxt = RX_DATA[ADDR_WIDTH-1:0];
          state_nxt   = WR_DATA;
        end
        WR_DATA: if (RX_DATA_VALID) begin
          rf_wr_data_nxt = RX_DATA;
          rf_wr_en_nxt   = 1'b1;
          state_nxt      = IDLE;
        end
        RD_ADDR: if (RX_DATA_VALID) begin
          rf_addr_nxt  = RX_DATA[ADDR_WIDTH-1:0];
          rf_rd_en_nxt = 1'b1;
          state_nxt    = RD_WAIT;
        end
        // Responses push straight from the wait state when the FIFO has room,
        // so the first TX write follows the valid by a single cycle.
        RD_WAIT: if (RF_RD_VALID) begin
          result_nxt = {{DATA_WIDTH{1'b0}}, RF_RD_DATA};
          is_alu_nxt = 1'b0;
          if (!TX_FIFO_FULL) begin
            tx_wr_nxt   = 1'b1;
            tx_data_nxt = RF_RD_DATA;
            state_nxt   = IDLE;
          end else begin
            state_nxt   = SEND_LO;
          end
        end
        OPA: if (RX_DATA_VALID) begin
          rf_addr_nxt    = '0;
          rf_wr_data_nxt = RX_DATA;
          rf_wr_en_nxt   = 1'b1;
          state_nxt      = OPB;
        end
        OPB: if (RX_DATA_VALID) begin
          rf_addr_nxt    = ADDR_WIDTH'(1);
          rf_wr_data_nxt = RX_DATA;
          rf_wr_en_nxt   = 1'b1;
          state_nxt      = FUN;
        end
        FUN: if (RX_DATA_VALID) begin
          alu_fun_nxt = RX_DATA[ALU_FUN_WIDTH-1:0];
          alu_en_nxt  = 1'b1;
          state_nxt   = ALU_WAIT;
        end
        ALU_WAIT: if (ALU_OUT_VALID) begin
          result_nxt = ALU_OUT;
          is_alu_nxt = 1'b1;
          if (!TX_FIFO_FULL) begin
            tx_wr_nxt   = 1'b1;
            tx_data_nxt = ALU_OUT[DATA_WIDTH-1:0];
            state_nxt   = SEND_HI;
          end else begin
            state_nxt   = SEND_LO;
          end
        end
        SEND_LO: if (!TX_FIFO_FULL) begin
          tx_wr_nxt   = 1'b1;
          tx_data_nxt = result[DATA_WIDTH-1:0];
          state_nxt   = is_alu ? SEND_HI : IDLE;
        end
        SEND_HI: if (!TX_FIFO_FULL) begin
          tx_wr_nxt   = 1'b1;
          tx_data_nxt = result[2*DATA_WIDTH-1:DATA_WIDTH];
          state_nxt   = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule
